flattening_stream_buffer: RTL and testbench

- Parametrised successor to the flattening stage. Collects NumOfChannels per-channel pixel streams (from pooling or conv switches) into one flattened vector of NumOfChannels*ImageSize words, then hands it to the dense stage.
- Adds an optional ping-pong buffer so frame N+1 can fill while frame N is held for output.
- Adds valid/ready backpressure, a first-frame marker and a sticky overrun flag.

---
 rtl/flattening_stream_buffer.sv | 140 ++++++++++++++
 tb/tb_flattening_stream_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flattening_stream_buffer.sv
// Gathers per-channel pixel streams into one flattened frame, with optional
// ping-pong banking, valid/ready handshake, first-frame marker and sticky overrun flag.
module flattening_stream_buffer #(
  parameter int unsigned BitSize       = 2,
  parameter int unsigned ImageSize     = 9,
  parameter int unsigned NumOfChannels = 4,
  parameter int unsigned NumOfInputs   = 2,
  parameter int unsigned DoubleBuffer  = 1
) (
  input  logic                                        clk,
  input  logic                                        res,
  input  logic [NumOfChannels-1:0]                    in_valid,
  input  logic [NumOfInputs*BitSize-1:0]              in_data,
  output logic                                        in_ready,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_first,
  output logic [NumOfChannels*ImageSize*BitSize-1:0]  out_data,
  output logic                                        err_overrun
);

  localparam int unsigned Total = NumOfChannels * ImageSize;
  localparam int unsigned CntW  = $clog2(ImageSize + 1);
  localparam int unsigned AddrW = (Total > 1) ? $clog2(Total) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_e;

  bank_state_e          r_state      [2];
  bank_state_e          w_state_next [2];
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic                 r_first_done;
  logic                 r_err;
  logic [CntW-1:0]      r_cnt [NumOfChannels];
  logic [BitSize-1:0]   r_mem [2][Total];

  logic [NumOfChannels-1:0] w_accept;
  logic [NumOfChannels-1:0] w_overrun;
  logic [NumOfChannels-1:0] w_chan_done;
  logic [AddrW-1:0]         w_addr [NumOfChannels];
  logic [BitSize-1:0]       w_lane [NumOfChannels];
  logic                     w_complete;
  logic                     w_handshake;

  assign in_ready    = (r_state[r_wr_bank] != BANK_FULL);
  assign out_valid   = (r_state[r_rd_bank] == BANK_FULL);
  assign out_first   = out_valid & ~r_first_done;
  assign err_overrun = r_err;
  assign w_handshake = out_valid & out_ready;

  // Per-channel accept/overrun decode and write addressing
  always_comb begin
    for (int c = 0; c < NumOfChannels; c++) begin
      w_accept[c]    = in_ready & in_valid[c] & (r_cnt[c] <  CntW'(ImageSize));
      w_overrun[c]   = in_ready & in_valid[c] & (r_cnt[c] == CntW'(ImageSize));
      w_chan_done[c] = ((r_cnt[c] + CntW'(w_accept[c])) == CntW'(ImageSize));
      w_addr[c]      = AddrW'(c * ImageSize) + AddrW'(r_cnt[c]);
      w_lane[c]      = in_data[(c % NumOfInputs) * BitSize +: BitSize];
    end
    w_complete = (&w_chan_done) & (|w_accept);
  end

  // Bank state next-state: the handshake bank and the write bank differ
  // whenever both events can happen on one edge.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_next[b] = r_state[b];
    end
    if (w_handshake) begin
      w_state_next[r_rd_bank] = BANK_EMPTY;
    end
    if ((|w_accept) && (r_state[r_wr_bank] == BANK_EMPTY)) begin
      w_state_next[r_wr_bank] = BANK_FILLING;
    end
    if (w_complete) begin
      w_state_next[r_wr_bank] = BANK_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= BANK_EMPTY;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_state[b] <= w_state_next[b];
      end
    end
  end

  // Storage, counters, bank pointers and flags
  always_ff @(posedge clk) begin
    if (res) begin
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_first_done <= 1'b0;
      r_err        <= 1'b0;
      for (int c = 0; c < NumOfChannels; c++) begin
        r_cnt[c] <= '0;
      end
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < Total; i++) begin
          r_mem[b][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NumOfChannels; c++) begin
        if (w_accept[c]) begin
          r_mem[r_wr_bank][w_addr[c]] <= w_lane[c];
        end
        r_cnt[c] <= w_complete ? '0 : r_cnt[c] + CntW'(w_accept[c]);
      end
      if (|w_overrun) begin
        r_err <= 1'b1;
      end
      if (w_complete && (DoubleBuffer != 0)) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_handshake) begin
        r_first_done <= 1'b1;
        if (DoubleBuffer != 0) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < Total; i++) begin
      out_data[i*BitSize +: BitSize] = r_mem[r_rd_bank][i];
    end
  end

endmodule

// File: tb/tb_flattening_stream_buffer.sv
// Directed bench: table-driven single frame, then hand-written sequences for
// staggering, overrun, reset, backpressure and the single-bank variant.
module tb_flattening_stream_buffer;

  logic        clk;
  logic        res;
  logic [3:0]  in_valid;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, out_ready, out_first, err_overrun;
  logic [71:0] out_data;
  logic        in_ready0, out_valid0, out_ready0, out_first0, err_overrun0;
  logic [71:0] out_data0;

  int errors = 0;
  int checks = 0;
  logic [71:0] exp_vec;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] dat;
    logic       ordy;
    logic       e_ird;
    logic       e_ovld;
    logic       e_ofirst;
    logic       e_err;
  } vec_t;

  vec_t tbl [20];

  flattening_stream_buffer dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_data(out_data), .err_overrun(err_overrun)
  );

  flattening_stream_buffer #(.DoubleBuffer(0)) dut0 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_first(out_first0), .out_data(out_data0), .err_overrun(err_overrun0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string nm, input logic [71:0] act);
    checks++;
    if (act !== exp_vec) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_vec, $time);
    end
  endtask

  function automatic logic [1:0] pat(input int c, input int p, input int b);
    return 2'((p + c + b) % 4);
  endfunction

  function automatic logic [1:0] a_val(input int p);
    return 2'((3 * p + 1) % 4);
  endfunction

  task automatic set_pat(input int b);
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 9; p++)
        exp_vec[(c*9+p)*2 +: 2] = pat(c, p, b);
  endtask

  // Channels 0/1 then 2/3 alternate, since channel pairs share a lane
  task automatic feed_frame(input int b);
    for (int p = 0; p < 9; p++) begin
      in_valid = 4'b0011; in_data = {pat(1, p, b), pat(0, p, b)}; tick();
      in_valid = 4'b1100; in_data = {pat(3, p, b), pat(2, p, b)}; tick();
    end
    in_valid = 4'b0000; in_data = 4'b0000;
  endtask

  task automatic do_reset();
    res = 1'b1; tick(); res = 1'b0;
  endtask

  initial begin
    res = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0; out_ready0 = 1'b0;
    #1;
    do_reset();

    exp_vec = '0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_err", err_overrun, 1'b0);
    chk_data("rst_out_data", out_data);
    chk("rst_in_ready0", in_ready0, 1'b1);
    chk("rst_out_valid0", out_valid0, 1'b0);

    // Single frame, table-driven
    for (int i = 0; i < 20; i++) begin
      if (i < 18) begin
        tbl[i].vld = (i % 2 == 0) ? 4'b0011 : 4'b1100;
        tbl[i].dat = (i % 2 == 0) ? {pat(1, i/2, 0), pat(0, i/2, 0)}
                                  : {pat(3, i/2, 0), pat(2, i/2, 0)};
      end else begin
        tbl[i].vld = 4'b0000;
        tbl[i].dat = 4'b0000;
      end
      tbl[i].ordy     = 1'b1;
      tbl[i].e_ird    = 1'b1;
      tbl[i].e_ovld   = (i == 17);
      tbl[i].e_ofirst = (i == 17);
      tbl[i].e_err    = 1'b0;
    end
    set_pat(0);
    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].vld; in_data = tbl[i].dat; out_ready = tbl[i].ordy;
      tick();
      chk("t1_in_ready", in_ready, tbl[i].e_ird);
      chk("t1_out_valid", out_valid, tbl[i].e_ovld);
      chk("t1_out_first", out_first, tbl[i].e_ofirst);
      chk("t1_err", err_overrun, tbl[i].e_err);
      if (tbl[i].e_ovld) chk_data("t1_data", out_data);
    end

    // Staggered: channels 1/3 finish 5 cycles after channels 0/2
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 9; p++)
        exp_vec[(c*9+p)*2 +: 2] = (c % 2 == 0) ? a_val(p) : 2'((p + 2) % 4);
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      in_valid = ((k < 9) ? 4'b0101 : 4'b0000) | ((k >= 5) ? 4'b1010 : 4'b0000);
      in_data  = {(k >= 5) ? 2'((k - 5 + 2) % 4) : 2'b00, (k < 9) ? a_val(k) : 2'b00};
      tick();
      chk("stag_out_valid", out_valid, (k == 13));
    end
    in_valid = '0;
    chk_data("stag_data", out_data);
    chk("stag_out_first", out_first, 1'b0);
    tick();
    chk("stag_released", out_valid, 1'b0);

    // Overrun: channel 1 gets a 10th pixel while channel 2 is still empty
    for (int p = 0; p < 10; p++) begin
      in_valid = 4'b0010;
      in_data  = {(p < 9) ? 2'((p + 1) % 4) : 2'd3, 2'b00};
      tick();
      chk("ovr_err", err_overrun, (p == 9));
    end
    for (int p = 0; p < 9; p++) begin
      in_valid = 4'b1101; in_data = {2'((p + 3) % 4), a_val(p)};
      tick();
    end
    in_valid = '0;
    for (int p = 0; p < 9; p++) begin
      exp_vec[(0*9+p)*2 +: 2] = a_val(p);
      exp_vec[(1*9+p)*2 +: 2] = 2'((p + 1) % 4);
      exp_vec[(2*9+p)*2 +: 2] = a_val(p);
      exp_vec[(3*9+p)*2 +: 2] = 2'((p + 3) % 4);
    end
    chk("ovr_out_valid", out_valid, 1'b1);
    chk_data("ovr_data", out_data);
    chk("ovr_err_sticky", err_overrun, 1'b1);
    tick();
    chk("ovr_err_after_hs", err_overrun, 1'b1);
    chk("ovr_released", out_valid, 1'b0);

    // Reset with one bank FULL and one FILLING
    out_ready = 1'b0;
    feed_frame(1);
    chk("rm_full", out_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b1111; in_data = 4'b1001; tick();
    end
    in_valid = '0;
    chk("rm_in_ready_pre", in_ready, 1'b1);
    do_reset();
    exp_vec = '0;
    chk("rm_out_valid", out_valid, 1'b0);
    chk("rm_in_ready", in_ready, 1'b1);
    chk("rm_err", err_overrun, 1'b0);
    chk("rm_out_first", out_first, 1'b0);
    chk_data("rm_out_data", out_data);

    // Backpressure with two banks: third frame must be ignored
    feed_frame(0);
    chk("bp_v1", out_valid, 1'b1);
    chk("bp_first1", out_first, 1'b1);
    chk("bp_ready1", in_ready, 1'b1);
    feed_frame(1);
    chk("bp_ready2", in_ready, 1'b0);
    feed_frame(2);
    chk("bp_ready3", in_ready, 1'b0);
    chk("bp_err", err_overrun, 1'b0);
    set_pat(0);
    chk("bp_first_f1", out_first, 1'b1);
    chk_data("bp_data_f1", out_data);
    out_ready = 1'b1;
    tick();
    set_pat(1);
    chk("bp_v2", out_valid, 1'b1);
    chk("bp_first_f2", out_first, 1'b0);
    chk_data("bp_data_f2", out_data);
    chk("bp_ready_after", in_ready, 1'b1);
    tick();
    chk("bp_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Single bank: stalls until the frame is taken
    do_reset();
    chk("db0_rst_ready", in_ready0, 1'b1);
    feed_frame(3);
    set_pat(3);
    chk("db0_valid", out_valid0, 1'b1);
    chk("db0_first", out_first0, 1'b1);
    chk_data("db0_data", out_data0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("db0_stall_ready", in_ready0, 1'b0);
    end
    out_ready0 = 1'b1;
    tick();
    chk("db0_ready_after_hs", in_ready0, 1'b1);
    chk("db0_valid_after_hs", out_valid0, 1'b0);
    chk("db0_err", err_overrun0, 1'b0);
    out_ready0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
